// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface FSM: ERROR_RESET/ERROR_WAIT/READY/STARTED/CONNECTING/RUN with internal interval timer.
// Latency: outputs decode the state register, so they follow a triggering input by one clock.
// Backpressure: none; inputs are levels/pulses sampled every clock. Optional `SPW_LINK_ERR_LOG_EN builds last_error capture.
module spw_link_fsm #(
  parameter int T_6US4  = 320,
  parameter int T_12US8 = 640,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       link_start,
  input  logic       link_disable,
  input  logic       auto_start,
  input  logic       got_null,
  input  logic       got_fct,
  input  logic       got_nchar,
  input  logic       got_time_code,
  input  logic       err_disc,
  input  logic       err_par,
  input  logic       err_esc,
  input  logic       err_credit,
  output logic [2:0] current_state,
  output logic       rx_reset,
  output logic       tx_reset,
  output logic       tx_null_only,
  output logic       tx_fct_en,
  output logic       tx_data_en,
  output logic [2:0] last_error
);

  localparam logic [2:0] S_ERROR_RESET = 3'd0;
  localparam logic [2:0] S_ERROR_WAIT  = 3'd1;
  localparam logic [2:0] S_READY       = 3'd2;
  localparam logic [2:0] S_STARTED     = 3'd3;
  localparam logic [2:0] S_CONNECTING  = 3'd4;
  localparam logic [2:0] S_RUN         = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic link_en;
  logic rx_err;
  logic rx_char;
  logic tmo_6;
  logic tmo_12;
  // One bit per error cause; bit i corresponds to error code i+1.
  logic [6:0] cause_vec;

  assign link_en = !link_disable & (link_start | (auto_start & got_null));
  assign rx_err  = err_disc | err_par | err_esc;
  assign rx_char = got_fct | got_nchar | got_time_code;
  assign tmo_6   = (timer_q == TW'(T_6US4 - 1));
  assign tmo_12  = (timer_q == TW'(T_12US8 - 1));

  // Next state: collect the error causes valid in this state; any error overrides timeout/advance.
  always_comb begin
    state_d   = state_q;
    cause_vec = 7'b0;
    case (state_q)
      S_ERROR_RESET: begin
        if (tmo_6) state_d = S_ERROR_WAIT;
      end
      S_ERROR_WAIT: begin
        cause_vec = {1'b0, 1'b0, rx_char, 1'b0, err_esc, err_par, err_disc};
        if (tmo_12) state_d = S_READY;
      end
      S_READY: begin
        cause_vec = {1'b0, 1'b0, rx_char, 1'b0, err_esc, err_par, err_disc};
        if (link_en) state_d = S_STARTED;
      end
      S_STARTED: begin
        cause_vec = {link_disable, tmo_12, rx_char, 1'b0, err_esc, err_par, err_disc};
        if (got_null) state_d = S_CONNECTING;
      end
      S_CONNECTING: begin
        // FCT is the expected advance here; only N-Chars and time-codes are premature.
        cause_vec = {link_disable, tmo_12, got_nchar | got_time_code, 1'b0, err_esc, err_par, err_disc};
        if (got_fct) state_d = S_RUN;
      end
      S_RUN: begin
        cause_vec = {link_disable, 1'b0, 1'b0, err_credit, err_esc, err_par, err_disc};
      end
      default: begin
        // Unused codes recover through the normal reset sequence.
        state_d = S_ERROR_RESET;
      end
    endcase
    if (|cause_vec) state_d = S_ERROR_RESET;
  end

  // Interval timer: restart on every state change, otherwise count up and saturate.
  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // State and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ERROR_RESET;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Output decode straight from the state register.
  always_comb begin
    current_state = state_q;
    rx_reset      = 1'b0;
    tx_reset      = 1'b0;
    tx_null_only  = 1'b0;
    tx_fct_en     = 1'b0;
    tx_data_en    = 1'b0;
    case (state_q)
      S_ERROR_WAIT, S_READY: tx_reset = 1'b1;
      S_STARTED:             tx_null_only = 1'b1;
      S_CONNECTING:          tx_fct_en = 1'b1;
      S_RUN: begin
        tx_fct_en  = 1'b1;
        tx_data_en = 1'b1;
      end
      default: begin
        rx_reset = 1'b1;
        tx_reset = 1'b1;
      end
    endcase
  end

`ifdef SPW_LINK_ERR_LOG_EN
  logic [2:0] last_error_q, last_error_d;

  // Capture the lowest-numbered active cause; cause_vec is only non-zero on an error transition.
  always_comb begin
    last_error_d = last_error_q;
    for (int i = 6; i >= 0; i--) begin
      if (cause_vec[i]) last_error_d = 3'(i + 1);
    end
  end

  // Error log register, held until the next error or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_error_q <= 3'd0;
    end else begin
      last_error_q <= last_error_d;
    end
  end

  assign last_error = last_error_q;
`else
  assign last_error = 3'd0;
`endif

endmodule
